// File: rtl/count_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_pkg
// Description : Shared state encoding and default width for the counter family.
// Revision    : 1.0 - initial release
// ============================================================================
package count_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/count4_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : count4_down_timer
// Description : Loadable down-counting timer with one-cycle terminal-count
//               pulse and optional auto-reload from a captured start value.
// Revision    : 1.0 - initial release
// ============================================================================
module count4_down_timer
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] i,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] next_reload;
    logic [WIDTH-1:0] next_q;
    logic             next_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            q          <= C_ZERO;
            tc         <= 1'b0;
            busy       <= 1'b0;
            reload_reg <= C_ZERO;
        end else begin
            state      <= next_state;
            q          <= next_q;
            tc         <= next_tc;
            busy       <= (next_state == RUN);
            reload_reg <= next_reload;
        end
    end

    always_comb begin
        next_state  = state;
        next_q      = q;
        next_tc     = 1'b0;
        next_reload = reload_reg;

        if (load) begin
            next_q      = i;
            next_reload = i;
            // A zero start value expires immediately rather than running.
            if (i != C_ZERO) begin
                next_state = RUN;
            end else begin
                next_state = DONE;
                next_tc    = 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    if (en) begin
                        if (q > C_ONE) begin
                            next_q = q - C_ONE;
                        end else begin
                            next_q     = C_ZERO;
                            next_tc    = 1'b1;
                            next_state = DONE;
                        end
                    end
                end
                DONE: begin
                    if (auto_reload && (reload_reg != C_ZERO)) begin
                        next_q     = reload_reg;
                        next_state = RUN;
                    end else begin
                        next_q     = C_ZERO;
                        next_state = IDLE;
                    end
                end
                IDLE: begin
                    next_state = IDLE;
                end
                default: begin
                    next_q     = C_ZERO;
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count4_down_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_count4_down_timer
// Description : Directed vector bench for count4_down_timer (4- and 6-bit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count4_down_timer;

    typedef struct {
        logic       load;
        logic [3:0] i;
        logic       en;
        logic       ar;
        logic [3:0] q;
        logic       tc;
        logic       busy;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] i;
    logic       en;
    logic       auto_reload;
    logic [3:0] q;
    logic       tc;
    logic       busy;

    logic       load6;
    logic [5:0] i6;
    logic       en6;
    logic       ar6;
    logic [5:0] q6;
    logic       tc6;
    logic       busy6;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    count4_down_timer #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .i(i), .en(en),
        .auto_reload(auto_reload), .q(q), .tc(tc), .busy(busy)
    );

    count4_down_timer #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(reset), .load(load6), .i(i6), .en(en6),
        .auto_reload(ar6), .q(q6), .tc(tc6), .busy(busy6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic ld, input logic [3:0] iv, input logic e,
                                input logic a, input logic [3:0] eq, input logic et,
                                input logic eb);
        vec_t v;
        v.load = ld; v.i = iv; v.en = e; v.ar = a;
        v.q = eq; v.tc = et; v.busy = eb;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int edges;
        int prev;

        reset = 1'b1; load = 1'b0; i = '0; en = 1'b0; auto_reload = 1'b0;
        load6 = 1'b0; i6 = '0; en6 = 1'b0; ar6 = 1'b0;

        // Load 13, count to zero, pulse, park in IDLE ignoring en.
        add(1, 4'd13, 1, 0, 4'd13, 0, 1);
        for (int k = 12; k >= 1; k--) add(0, 4'd0, 1, 0, 4'(k), 0, 1);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);
        add(0, 4'd0, 1, 0, 4'd0, 0, 0);
        add(0, 4'd0, 1, 1, 4'd0, 0, 0);
        // Auto-reload 3: period of 4 edges, busy low only in DONE.
        add(1, 4'd3, 1, 1, 4'd3, 0, 1);
        add(0, 4'd0, 1, 1, 4'd2, 0, 1);
        add(0, 4'd0, 1, 1, 4'd1, 0, 1);
        add(0, 4'd0, 1, 1, 4'd0, 1, 0);
        add(0, 4'd0, 1, 1, 4'd3, 0, 1);
        add(0, 4'd0, 1, 1, 4'd2, 0, 1);
        add(0, 4'd0, 1, 1, 4'd1, 0, 1);
        add(0, 4'd0, 1, 1, 4'd0, 1, 0);
        add(0, 4'd0, 1, 0, 4'd0, 0, 0);
        // Load 5 with en 1,0,0,1: two-cycle stretch.
        add(1, 4'd5, 0, 0, 4'd5, 0, 1);
        add(0, 4'd0, 1, 0, 4'd4, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(0, 4'd0, 0, 0, 4'd4, 0, 1);
        add(0, 4'd0, 1, 0, 4'd3, 0, 1);
        add(0, 4'd0, 1, 0, 4'd2, 0, 1);
        add(0, 4'd0, 1, 0, 4'd1, 0, 1);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);
        add(0, 4'd0, 1, 0, 4'd0, 0, 0);
        // Load 0: immediate expiry, no reload from a zero reload value.
        add(1, 4'd0, 1, 1, 4'd0, 1, 0);
        add(0, 4'd0, 1, 1, 4'd0, 0, 0);
        // Load 2 exactly when q==1 with en high: load wins, no tc.
        add(1, 4'd3, 1, 0, 4'd3, 0, 1);
        add(0, 4'd0, 1, 0, 4'd2, 0, 1);
        add(0, 4'd0, 1, 0, 4'd1, 0, 1);
        add(1, 4'd2, 1, 0, 4'd2, 0, 1);
        add(0, 4'd0, 1, 0, 4'd1, 0, 1);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);
        // Load during DONE: tc drops, counting resumes from the new value.
        add(1, 4'd2, 0, 1, 4'd2, 0, 1);
        add(0, 4'd0, 0, 1, 4'd2, 0, 1);
        add(0, 4'd0, 1, 1, 4'd1, 0, 1);
        add(0, 4'd0, 1, 1, 4'd0, 1, 0);
        add(0, 4'd0, 0, 0, 4'd0, 0, 0);
        // Full-scale 15 on the 4-bit instance.
        add(1, 4'd15, 1, 0, 4'd15, 0, 1);
        for (int k = 14; k >= 1; k--) add(0, 4'd0, 1, 0, 4'(k), 0, 1);
        add(0, 4'd0, 1, 0, 4'd0, 1, 0);
        add(0, 4'd0, 1, 0, 4'd0, 0, 0);

        tick();
        tick();
        reset = 1'b0;
        chk("reset_q", -1, int'(q), 0);
        chk("reset_tc", -1, int'(tc), 0);
        chk("reset_busy", -1, int'(busy), 0);
        chk("reset_q6", -1, int'(q6), 0);

        foreach (vecs[n]) begin
            load = vecs[n].load; i = vecs[n].i; en = vecs[n].en; auto_reload = vecs[n].ar;
            tick();
            chk("vec_q", n, int'(q), int'(vecs[n].q));
            chk("vec_tc", n, int'(tc), int'(vecs[n].tc));
            chk("vec_busy", n, int'(busy), int'(vecs[n].busy));
        end

        // Reset in mid-run clears outputs; en alone cannot restart.
        load = 1'b1; i = 4'd8; en = 1'b1; auto_reload = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("mid_q_before_reset", 0, int'(q), 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_q", 0, int'(q), 0);
        chk("rst_mid_tc", 0, int'(tc), 0);
        chk("rst_mid_busy", 0, int'(busy), 0);
        repeat (3) tick();
        chk("post_rst_q", 0, int'(q), 0);
        chk("post_rst_busy", 0, int'(busy), 0);
        chk("post_rst_tc", 0, int'(tc), 0);
        en = 1'b0; auto_reload = 1'b0;

        // 6-bit instance: 63 enabled edges to terminal count, no wrap.
        load6 = 1'b1; i6 = 6'h3F; en6 = 1'b1; ar6 = 1'b0;
        tick();
        load6 = 1'b0;
        chk("w6_load_q", 0, int'(q6), 63);
        chk("w6_load_busy", 0, int'(busy6), 1);
        edges = 0;
        prev  = 63;
        while (!tc6 && edges < 100) begin
            tick();
            edges++;
            if (int'(q6) != prev - 1) begin
                chk("w6_step", edges, int'(q6), prev - 1);
            end
            prev = int'(q6);
        end
        chk("w6_edges", 0, edges, 63);
        chk("w6_tc_q", 0, int'(q6), 0);
        tick();
        chk("w6_after_q", 0, int'(q6), 0);
        chk("w6_after_tc", 0, int'(tc6), 0);
        chk("w6_after_busy", 0, int'(busy6), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count4_down_timer.md
# count4_down_timer

Loadable down-counting timer, the complementary counting direction to the team's 4-bit loadable up-counter. It loads a start value and decrements once per enabled cycle. On reaching zero it emits a one-cycle terminal-count pulse, then either auto-reloads or parks idle. It sits beside the up-counter as the event/timeout generator for the same datapath and reuses its load/value port style.

## Interface
- WIDTH, 4, counter/load width in bits

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load  input  1  capture `i` into count and reload register
- i  input  WIDTH  load value
- en  input  1  decrement enable (RUN state only)
- auto_reload  input  1  on terminal count, restart from the reload register
- q  output  WIDTH  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle
- busy  output  1  high while in RUN

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: q=0, tc=0, busy=0, reload_reg=0, state=IDLE.
- Priority, highest first: reset, load, state action.
- load=1 (any state):
  - q<=i, reload_reg<=i, tc<=0.
  - If i!=0, go to RUN. If i==0, go to DONE with tc<=1 (immediate expiry).
- RUN:
  - en=0: hold q, tc=0.
  - en=1, q>1: q<=q-1.
  - en=1, q==1: q<=0, tc<=1, go to DONE.
- DONE (lasts exactly one cycle, tc=1 during it):
  - auto_reload=1 and reload_reg!=0: q<=reload_reg, go to RUN.
  - Otherwise: q holds 0, go to IDLE.
  - `en` is ignored in DONE.
- IDLE: q holds; `en` and `auto_reload` are ignored. Only `load` leaves IDLE.
- busy = (state==RUN), driven from registered state.
- Arithmetic: unsigned WIDTH bits. q never wraps below 0 because the decrement is never applied at q==0.
- auto_reload is sampled in DONE, not at load time.

## Timing
- load sampled at edge N: q=i and busy=1 are visible after edge N.
- Count latency with en held high: q reaches 0 and tc=1 after V enabled edges following the load edge (V = loaded value).
- Auto-reload period: one tc pulse every V+1 edges (V decrements plus the DONE cycle). q goes 1 -> 0 -> V.
- tc is always a single-cycle pulse, coincident with q==0 in DONE.
- load in the same cycle as q==1 and en=1: load wins; q<=i and no tc.
- load during DONE: load wins; tc drops on the next edge.
- reset mid-RUN: all outputs return to reset values at the next edge; reload_reg is cleared.
- WIDTH max value (all ones) counts the full 2^WIDTH-1 steps.

## Structure
- Shared package `count_pkg`: state enum {IDLE, RUN, DONE}, default width constant COUNT_W=4. This is shared with the up-counter.
- Single module, no sub-module required. Next-state logic and output registers sit in one module.
- q, tc, busy, reload_reg and state are all flops. There are no combinational outputs.

## Test plan
- Reset 15 time units, then load=1, i=4'b1101 for one cycle, en=1, auto_reload=0 -> q counts 13..0; tc=1 for exactly one cycle at q=0; busy falls; q stays 0 in IDLE.
- Load 4'b0011, auto_reload=1, en=1 -> q sequence 3,2,1,0,3,2,1,0; tc every 4 edges; busy low only in the DONE cycles.
- Load 4'b0101, toggle en 1,0,0,1 -> q holds during en=0; tc delayed by 2 cycles relative to continuous enable.
- Load 4'b1000, assert reset at q=4 for one cycle -> q=0, tc=0, busy=0 next edge; en afterwards has no effect until a new load.
- Load 4'b0000 -> tc=1 next cycle, then IDLE. Separately, load 4'b0010 asserted exactly when q==1 -> q=2, no tc pulse.
- WIDTH=6, load 6'h3F, en=1 -> tc after 63 edges; no wrap past 0.
